// File: rtl/fifo_arb_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fifo_arb_pkg : shared types and helpers for the FIFO write-port arbiter
// Rev 1.0
// ----------------------------------------------------------------------------
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Ceiling log2, never below 1 so index ports always have at least one bit.
  function automatic int clog2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if (value > (1 << i)) r = i + 1;
    end
    return r;
  endfunction

  localparam int NREQ_DEF = 4;
  localparam int GW       = clog2(NREQ_DEF);

endpackage
`default_nettype wire

// File: rtl/fifo_wr_arbiter_rr_pick.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rr_pick : combinational round-robin selector, first request after i_last
// Rev 1.0
// ----------------------------------------------------------------------------
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_last,
  output logic [IW-1:0]   o_idx,
  output logic            o_any
);

  // Scan from farthest to nearest so the nearest valid candidate wins; the
  // last pointer itself is the final candidate, giving self re-grant.
  always_comb begin
    o_idx = '0;
    o_any = 1'b0;
    for (int k = NREQ; k >= 1; k--) begin
      if (i_req[(int'(i_last) + k) % NREQ]) begin
        o_idx = IW'((int'(i_last) + k) % NREQ);
        o_any = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fifo_wr_arbiter : round-robin, burst-bounded scheduler for a FIFO write port
// Rev 1.0
// ----------------------------------------------------------------------------
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int DSIZE = 8,
  parameter int BURST = 4,
  parameter int CNTW  = 16
) (
  input  logic                     wclk,
  input  logic                     wrst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*DSIZE-1:0]    req_data,
  output logic [NREQ-1:0]          req_ready,
  input  logic                     wfull,
  output logic                     winc,
  output logic [DSIZE-1:0]         wdata,
  output logic [clog2(NREQ)-1:0]   grant_id,
  output logic                     busy,
  output logic [CNTW-1:0]          wr_count
);

  localparam int              c_gw        = clog2(NREQ);
  localparam int              c_bw        = clog2(BURST);
  localparam logic [c_bw-1:0] c_last_beat = c_bw'(BURST - 1);
  localparam logic [c_gw-1:0] c_last_rst  = c_gw'(NREQ - 1);

  arb_state_t        r_state;
  logic [c_gw-1:0]   r_grant;
  logic [c_gw-1:0]   r_last;
  logic [c_bw-1:0]   r_beat;
  logic [CNTW-1:0]   r_wr_count;

  logic              w_in_grant;
  logic              w_gvalid;
  logic              w_winc;
  logic              w_release;
  logic [c_gw-1:0]   w_pick_last;
  logic [c_gw-1:0]   w_pick;
  logic              w_any;

  assign w_in_grant = (r_state == GRANT);
  assign w_gvalid   = req_valid[r_grant];
  assign w_winc     = w_in_grant && w_gvalid && !wfull;
  // A stalled grant never releases; otherwise release on the last beat or
  // when the owner has nothing to send.
  assign w_release  = w_in_grant && !wfull && (!w_gvalid || (r_beat == c_last_beat));

  // The same picker serves IDLE arbitration and back-to-back re-arbitration.
  assign w_pick_last = w_in_grant ? r_grant : r_last;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (c_gw)
  ) u_rr_pick (
    .i_req  (req_valid),
    .i_last (w_pick_last),
    .o_idx  (w_pick),
    .o_any  (w_any)
  );

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      r_state    <= IDLE;
      r_grant    <= '0;
      r_last     <= c_last_rst;
      r_beat     <= '0;
      r_wr_count <= '0;
    end else begin
      if (w_winc) begin
        r_beat     <= r_beat + 1'b1;
        r_wr_count <= r_wr_count + 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_grant <= w_pick;
            r_beat  <= '0;
            r_state <= GRANT;
          end
        end
        GRANT: begin
          if (w_release) begin
            r_last <= r_grant;
            r_beat <= '0;
            if (w_any) begin
              r_grant <= w_pick;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    req_ready = '0;
    if (w_in_grant) req_ready[r_grant] = !wfull;
  end

  assign winc     = w_winc;
  assign wdata    = w_in_grant ? req_data[r_grant*DSIZE +: DSIZE] : '0;
  assign grant_id = r_grant;
  assign busy     = w_in_grant;
  assign wr_count = r_wr_count;

  a_no_winc_when_full: assert property (@(posedge wclk) disable iff (wrst)
    !(winc && wfull));
  a_ready_onehot0: assert property (@(posedge wclk) disable iff (wrst)
    $onehot0(req_ready));
  a_winc_has_valid: assert property (@(posedge wclk) disable iff (wrst)
    winc |-> req_valid[grant_id]);

endmodule
`default_nettype wire
